// File: rtl/ddr4_v2_2_20_upsizer_rr_arbiter.sv
// Round-robin arbiter sharing one upsizer command port between C_NUM_REQ requesters.
// Winner payload and index are registered; back-to-back grants on accept.
module ddr4_v2_2_20_upsizer_rr_arbiter #(
    parameter string       C_FAMILY        = "virtex6",
    parameter int unsigned C_NUM_REQ       = 4,
    parameter int unsigned C_PAYLOAD_WIDTH = 32
) (
    input  logic                                   ACLK,
    input  logic                                   ARESETN,
    input  logic [C_NUM_REQ-1:0]                   S_REQ,
    input  logic [C_NUM_REQ*C_PAYLOAD_WIDTH-1:0]   S_PAYLOAD,
    output logic [C_NUM_REQ-1:0]                   S_ACK,
    output logic                                   M_VALID,
    input  logic                                   M_READY,
    output logic [C_PAYLOAD_WIDTH-1:0]             M_PAYLOAD,
    output logic [$clog2(C_NUM_REQ)-1:0]           M_GRANT_IDX
);

    localparam int unsigned IdxW = $clog2(C_NUM_REQ);

    typedef enum logic [0:0] {StArb, StHold} state_e;

    state_e                     state_q, state_d;
    logic [IdxW-1:0]            ptr_q, ptr_d;
    logic [IdxW-1:0]            idx_q, idx_d;
    logic [C_PAYLOAD_WIDTH-1:0] payload_q, payload_d;
    logic [C_NUM_REQ-1:0]       ack_q, ack_d;

    logic [C_NUM_REQ-1:0]       win_mask;
    logic [C_NUM_REQ-1:0]       eligible;
    logic                       any_req;
    logic [C_NUM_REQ-1:0]       sel_oh;
    logic [IdxW-1:0]            sel_idx;
    logic [C_PAYLOAD_WIDTH-1:0] sel_payload;

    // The winner being accepted this cycle must not be regranted in the same cycle.
    always_comb begin
        win_mask = '0;
        for (int i = 0; i < int'(C_NUM_REQ); i++) begin
            win_mask[i] = (idx_q == IdxW'(i));
        end
    end

    assign eligible = (state_q == StHold && M_READY) ? (S_REQ & ~win_mask) : S_REQ;

    generate
        if (C_FAMILY == "rtl") begin : g_or_rtl
            assign any_req = |eligible;
        end else begin : g_or_chain
            logic [C_NUM_REQ:0] carry;
            assign carry[0] = 1'b0;
            for (genvar i = 0; i < int'(C_NUM_REQ); i++) begin : g_stage
                assign carry[i+1] = carry[i] | eligible[i];
            end
            assign any_req = carry[C_NUM_REQ];
        end
    endgenerate

    // Scan from ptr+1 upward with wrap; first eligible requester wins.
    always_comb begin
        logic [IdxW:0]   sum;
        logic [IdxW-1:0] j;
        logic            found;
        sel_oh  = '0;
        sel_idx = '0;
        found   = 1'b0;
        sum     = '0;
        j       = '0;
        for (int k = 1; k <= int'(C_NUM_REQ); k++) begin
            sum = {1'b0, ptr_q} + (IdxW+1)'(k);
            if (sum >= (IdxW+1)'(C_NUM_REQ)) begin
                sum = sum - (IdxW+1)'(C_NUM_REQ);
            end
            j = sum[IdxW-1:0];
            if (!found && eligible[j]) begin
                found     = 1'b1;
                sel_oh[j] = 1'b1;
                sel_idx   = j;
            end
        end
    end

    always_comb begin
        sel_payload = '0;
        for (int i = 0; i < int'(C_NUM_REQ); i++) begin
            sel_payload = sel_payload |
                (S_PAYLOAD[i*C_PAYLOAD_WIDTH +: C_PAYLOAD_WIDTH] & {C_PAYLOAD_WIDTH{sel_oh[i]}});
        end
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        idx_d     = idx_q;
        payload_d = payload_q;
        ack_d     = '0;
        unique case (state_q)
            StArb: begin
                if (any_req) begin
                    state_d   = StHold;
                    ptr_d     = sel_idx;
                    idx_d     = sel_idx;
                    payload_d = sel_payload;
                end
            end
            StHold: begin
                if (M_READY) begin
                    ack_d[idx_q] = 1'b1;
                    if (any_req) begin
                        ptr_d     = sel_idx;
                        idx_d     = sel_idx;
                        payload_d = sel_payload;
                    end else begin
                        state_d = StArb;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_q   <= StArb;
            ptr_q     <= IdxW'(C_NUM_REQ - 1);
            idx_q     <= '0;
            payload_q <= '0;
            ack_q     <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            idx_q     <= idx_d;
            payload_q <= payload_d;
            ack_q     <= ack_d;
        end
    end

    assign S_ACK       = ack_q;
    assign M_VALID     = (state_q == StHold);
    assign M_PAYLOAD   = payload_q;
    assign M_GRANT_IDX = idx_q;

endmodule

// File: tb/tb_ddr4_v2_2_20_upsizer_rr_arbiter.sv
// Directed table-driven bench for the round-robin upsizer arbiter (4 requesters, 32-bit payload).
module tb_ddr4_v2_2_20_upsizer_rr_arbiter;

    localparam int N = 4;
    localparam int W = 32;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [N-1:0]     s_req = '0;
    logic [N*W-1:0]   s_payload = '0;
    logic [N-1:0]     s_ack;
    logic             m_valid;
    logic             m_ready = 1'b0;
    logic [W-1:0]     m_payload;
    logic [1:0]       m_idx;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ddr4_v2_2_20_upsizer_rr_arbiter #(
        .C_FAMILY        ("virtex6"),
        .C_NUM_REQ       (N),
        .C_PAYLOAD_WIDTH (W)
    ) dut (
        .ACLK        (clk),
        .ARESETN     (rst_n),
        .S_REQ       (s_req),
        .S_PAYLOAD   (s_payload),
        .S_ACK       (s_ack),
        .M_VALID     (m_valid),
        .M_READY     (m_ready),
        .M_PAYLOAD   (m_payload),
        .M_GRANT_IDX (m_idx)
    );

    typedef struct packed {
        logic [3:0]  req;
        logic        ready;
        logic        alt;
        logic        exp_valid;
        logic [1:0]  exp_idx;
        logic [31:0] exp_pl;
        logic [3:0]  exp_ack;
    } vec_t;

    localparam int NV = 29;
    vec_t vecs [NV];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic set_payload(input logic alt);
        for (int i = 0; i < N; i++) begin
            s_payload[i*W +: W] = (alt ? 32'hDEAD_0000 : 32'hA5A5_0000) | 32'(i);
        end
    endtask

    task automatic check_outputs(input string tag, input logic v, input logic [1:0] idx,
                                 input logic [31:0] pl, input logic [3:0] ack);
        check({tag, ".valid"}, 32'(m_valid), 32'(v));
        check({tag, ".idx"}, 32'(m_idx), 32'(idx));
        check({tag, ".payload"}, m_payload, pl);
        check({tag, ".ack"}, 32'(s_ack), 32'(ack));
    endtask

    initial begin
        //            req      rdy   alt   vld   idx   payload         ack
        // full contention from reset pointer: 0,1,2,3,0
        vecs[0]  = '{4'b1111, 1'b1, 1'b0, 1'b1, 2'd0, 32'hA5A5_0000, 4'b0000};
        vecs[1]  = '{4'b1111, 1'b1, 1'b0, 1'b1, 2'd1, 32'hA5A5_0001, 4'b0001};
        vecs[2]  = '{4'b1111, 1'b1, 1'b0, 1'b1, 2'd2, 32'hA5A5_0002, 4'b0010};
        vecs[3]  = '{4'b1111, 1'b1, 1'b0, 1'b1, 2'd3, 32'hA5A5_0003, 4'b0100};
        vecs[4]  = '{4'b1111, 1'b1, 1'b0, 1'b1, 2'd0, 32'hA5A5_0000, 4'b1000};
        vecs[5]  = '{4'b0000, 1'b1, 1'b0, 1'b0, 2'd0, 32'hA5A5_0000, 4'b0001};
        vecs[6]  = '{4'b0000, 1'b1, 1'b0, 1'b0, 2'd0, 32'hA5A5_0000, 4'b0000};
        // single requester 2
        vecs[7]  = '{4'b0100, 1'b1, 1'b0, 1'b1, 2'd2, 32'hA5A5_0002, 4'b0000};
        vecs[8]  = '{4'b0100, 1'b1, 1'b0, 1'b0, 2'd2, 32'hA5A5_0002, 4'b0100};
        vecs[9]  = '{4'b0000, 1'b1, 1'b0, 1'b0, 2'd2, 32'hA5A5_0002, 4'b0000};
        // backpressure: winner 1 held while payloads change
        vecs[10] = '{4'b0010, 1'b0, 1'b0, 1'b1, 2'd1, 32'hA5A5_0001, 4'b0000};
        vecs[11] = '{4'b0011, 1'b0, 1'b1, 1'b1, 2'd1, 32'hA5A5_0001, 4'b0000};
        vecs[12] = '{4'b0011, 1'b0, 1'b1, 1'b1, 2'd1, 32'hA5A5_0001, 4'b0000};
        vecs[13] = '{4'b0011, 1'b0, 1'b1, 1'b1, 2'd1, 32'hA5A5_0001, 4'b0000};
        vecs[14] = '{4'b0011, 1'b0, 1'b1, 1'b1, 2'd1, 32'hA5A5_0001, 4'b0000};
        vecs[15] = '{4'b0011, 1'b0, 1'b1, 1'b1, 2'd1, 32'hA5A5_0001, 4'b0000};
        vecs[16] = '{4'b0011, 1'b1, 1'b1, 1'b1, 2'd0, 32'hDEAD_0000, 4'b0010};
        vecs[17] = '{4'b0001, 1'b1, 1'b1, 1'b0, 2'd0, 32'hDEAD_0000, 4'b0001};
        vecs[18] = '{4'b0000, 1'b1, 1'b0, 1'b0, 2'd0, 32'hDEAD_0000, 4'b0000};
        // move pointer to 3, then wrap/mask with 4'b1001
        vecs[19] = '{4'b1000, 1'b0, 1'b0, 1'b1, 2'd3, 32'hA5A5_0003, 4'b0000};
        vecs[20] = '{4'b1000, 1'b1, 1'b0, 1'b0, 2'd3, 32'hA5A5_0003, 4'b1000};
        vecs[21] = '{4'b0000, 1'b1, 1'b0, 1'b0, 2'd3, 32'hA5A5_0003, 4'b0000};
        vecs[22] = '{4'b1001, 1'b1, 1'b0, 1'b1, 2'd0, 32'hA5A5_0000, 4'b0000};
        vecs[23] = '{4'b1001, 1'b1, 1'b0, 1'b1, 2'd3, 32'hA5A5_0003, 4'b0001};
        vecs[24] = '{4'b1000, 1'b1, 1'b0, 1'b0, 2'd3, 32'hA5A5_0003, 4'b1000};
        vecs[25] = '{4'b0000, 1'b1, 1'b0, 1'b0, 2'd3, 32'hA5A5_0003, 4'b0000};
        // request withdrawn while granted: command and ack still happen
        vecs[26] = '{4'b0001, 1'b0, 1'b0, 1'b1, 2'd0, 32'hA5A5_0000, 4'b0000};
        vecs[27] = '{4'b0000, 1'b1, 1'b0, 1'b0, 2'd0, 32'hA5A5_0000, 4'b0001};
        vecs[28] = '{4'b0000, 1'b1, 1'b0, 1'b0, 2'd0, 32'hA5A5_0000, 4'b0000};

        set_payload(1'b0);
        repeat (2) @(posedge clk);
        #1;
        check_outputs("reset", 1'b0, 2'd0, 32'h0, 4'b0000);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_outputs("idle_after_reset", 1'b0, 2'd0, 32'h0, 4'b0000);

        for (int i = 0; i < NV; i++) begin
            s_req   = vecs[i].req;
            m_ready = vecs[i].ready;
            set_payload(vecs[i].alt);
            @(posedge clk);
            #1;
            check_outputs($sformatf("vec%0d", i), vecs[i].exp_valid, vecs[i].exp_idx,
                          vecs[i].exp_pl, vecs[i].exp_ack);
        end

        // Asynchronous reset while holding a command with an ack pulse in flight.
        set_payload(1'b0);
        s_req   = 4'b0011;
        m_ready = 1'b0;
        @(posedge clk);
        #1;
        check_outputs("pre_rst_grant", 1'b1, 2'd1, 32'hA5A5_0001, 4'b0000);
        m_ready = 1'b1;
        @(posedge clk);
        #1;
        check_outputs("pre_rst_b2b", 1'b1, 2'd0, 32'hA5A5_0000, 4'b0010);
        s_req   = 4'b0001;
        m_ready = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check_outputs("async_reset", 1'b0, 2'd0, 32'h0, 4'b0000);
        @(posedge clk);
        #1;
        check_outputs("in_reset", 1'b0, 2'd0, 32'h0, 4'b0000);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_outputs("post_rst_regrant", 1'b1, 2'd0, 32'hA5A5_0000, 4'b0000);
        m_ready = 1'b1;
        @(posedge clk);
        #1;
        check_outputs("post_rst_accept", 1'b0, 2'd0, 32'hA5A5_0000, 4'b0001);
        s_req = 4'b0000;
        @(posedge clk);
        #1;
        check_outputs("final_idle", 1'b0, 2'd0, 32'hA5A5_0000, 4'b0000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
